// File: rtl/mem_scan_unit_pkg.sv
// Shared widths, FSM encoding and length clamp for the memory scan engine.
package mem_scan_unit_pkg;

    localparam int unsigned ADDR_W    = 7;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned MEM_DEPTH = 2 ** ADDR_W;
    localparam int unsigned LEN_W     = 8;
    localparam int unsigned SUM_W     = DATA_W + ADDR_W;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StDrain,
        StDone
    } scan_state_e;

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        return (len > LEN_W'(MEM_DEPTH)) ? LEN_W'(MEM_DEPTH) : len;
    endfunction

endpackage

// File: rtl/mem_scan_unit_scan_accum.sv
// Valid-qualified statistics accumulator: sum, unsigned max with address, nonzero count.
module mem_scan_unit_scan_accum
    import mem_scan_unit_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clear,
    input  logic              i_valid,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_data,
    output logic [SUM_W-1:0]  o_sum,
    output logic [DATA_W-1:0] o_max_val,
    output logic [ADDR_W-1:0] o_max_idx,
    output logic [LEN_W-1:0]  o_nz_cnt
);

    logic [SUM_W-1:0]  r_sum;
    logic [DATA_W-1:0] r_max_val;
    logic [ADDR_W-1:0] r_max_idx;
    logic [LEN_W-1:0]  r_nz_cnt;
    logic              r_first;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum     <= '0;
            r_max_val <= '0;
            r_max_idx <= '0;
            r_nz_cnt  <= '0;
            r_first   <= 1'b1;
        end else if (i_clear) begin
            r_sum     <= '0;
            r_max_val <= '0;
            r_max_idx <= '0;
            r_nz_cnt  <= '0;
            r_first   <= 1'b1;
        end else if (i_valid) begin
            r_sum    <= r_sum + SUM_W'(i_data);
            r_nz_cnt <= r_nz_cnt + LEN_W'(i_data != '0);
            // Strict compare keeps the earliest address on ties; first word always loads.
            if (r_first || (i_data > r_max_val)) begin
                r_max_val <= i_data;
                r_max_idx <= i_addr;
            end
            r_first <= 1'b0;
        end
    end

    assign o_sum     = r_sum;
    assign o_max_val = r_max_val;
    assign o_max_idx = r_max_idx;
    assign o_nz_cnt  = r_nz_cnt;

endmodule

// File: rtl/mem_scan_unit.sv
// Sweeps a wrapping address window of the synchronous-read data memory and summarises it.
module mem_scan_unit
    import mem_scan_unit_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [LEN_W-1:0]  i_len,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_rd_en,
    input  logic [DATA_W-1:0] i_mem_data,
    output logic              o_busy,
    output logic              o_done,
    output logic [SUM_W-1:0]  o_sum,
    output logic [DATA_W-1:0] o_max_val,
    output logic [ADDR_W-1:0] o_max_idx,
    output logic [LEN_W-1:0]  o_nz_cnt
);

    scan_state_e       r_state;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_rd_en;
    logic              r_busy;
    logic              r_done;
    logic [LEN_W-1:0]  r_left;
    logic              r_valid;
    logic [ADDR_W-1:0] r_cap_addr;

    logic [LEN_W-1:0]  w_len;
    logic              w_accept;

    assign w_len    = clamp_len(i_len);
    assign w_accept = (r_state == StIdle) && i_start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_mem_addr <= '0;
            r_rd_en    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_left     <= '0;
            r_valid    <= 1'b0;
            r_cap_addr <= '0;
        end else begin
            // Memory returns data one cycle after the read is sampled.
            r_valid    <= r_rd_en;
            r_cap_addr <= r_mem_addr;
            unique case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_mem_addr <= i_base_addr;
                        if (w_len == '0) begin
                            r_state <= StDone;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= StRead;
                            r_rd_en <= 1'b1;
                            r_busy  <= 1'b1;
                            r_left  <= w_len - LEN_W'(1);
                        end
                    end
                end
                StRead: begin
                    if (r_left == '0) begin
                        r_rd_en <= 1'b0;
                        r_state <= StDrain;
                    end else begin
                        r_mem_addr <= r_mem_addr + ADDR_W'(1);
                        r_left     <= r_left - LEN_W'(1);
                    end
                end
                StDrain: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= StDone;
                end
                StDone: begin
                    r_done  <= 1'b0;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    mem_scan_unit_scan_accum u_accum (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (w_accept),
        .i_valid   (r_valid),
        .i_addr    (r_cap_addr),
        .i_data    (i_mem_data),
        .o_sum     (o_sum),
        .o_max_val (o_max_val),
        .o_max_idx (o_max_idx),
        .o_nz_cnt  (o_nz_cnt)
    );

    assign o_mem_addr  = r_mem_addr;
    assign o_mem_rd_en = r_rd_en;
    assign o_busy      = r_busy;
    assign o_done      = r_done;

endmodule

// File: tb/tb_mem_scan_unit.sv
// Directed bench for mem_scan_unit with a behavioural 128x32 synchronous-read memory.
module tb_mem_scan_unit;

    logic        clk;
    logic        rst_n;
    logic        i_start;
    logic [6:0]  i_base_addr;
    logic [7:0]  i_len;
    logic [6:0]  o_mem_addr;
    logic        o_mem_rd_en;
    logic [31:0] i_mem_data;
    logic        o_busy;
    logic        o_done;
    logic [38:0] o_sum;
    logic [31:0] o_max_val;
    logic [6:0]  o_max_idx;
    logic [7:0]  o_nz_cnt;

    logic [31:0] image [128];
    int          n_checks;
    int          n_fail;
    int          rd_cnt;
    int          done_cnt;
    logic [6:0]  addr_q [$];

    mem_scan_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (i_start),
        .i_base_addr (i_base_addr),
        .i_len       (i_len),
        .o_mem_addr  (o_mem_addr),
        .o_mem_rd_en (o_mem_rd_en),
        .i_mem_data  (i_mem_data),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_sum       (o_sum),
        .o_max_val   (o_max_val),
        .o_max_idx   (o_max_idx),
        .o_nz_cnt    (o_nz_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: shares rst_n, output clears on reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) i_mem_data <= '0;
        else if (o_mem_rd_en) i_mem_data <= image[o_mem_addr];
    end

    always @(negedge clk) begin
        if (o_mem_rd_en) begin
            rd_cnt = rd_cnt + 1;
            addr_q.push_back(o_mem_addr);
        end
        if (o_done) done_cnt = done_cnt + 1;
    end

    task automatic clear_mon();
        @(posedge clk); #1;
        rd_cnt = 0; done_cnt = 0; addr_q.delete();
    endtask

    // Starts one scan; lat = edges after the start edge until done is seen.
    task automatic run_scan(input logic [6:0] base, input logic [7:0] len, output int lat);
        clear_mon();
        @(negedge clk);
        i_start = 1'b1; i_base_addr = base; i_len = len;
        @(posedge clk); #1;
        i_start = 1'b0;
        lat = 0;
        while (!o_done && lat < 400) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; i_start = 1'b0; i_base_addr = '0; i_len = '0;
        repeat (3) @(negedge clk);
        n_checks++; if ({o_mem_addr, o_mem_rd_en, o_busy, o_done} !== 10'd0) begin
            n_fail++; $display("FAIL reset_ctrl: got %h expected 0", {o_mem_addr, o_mem_rd_en, o_busy, o_done}); end
        n_checks++; if ({o_sum, o_max_val, o_max_idx, o_nz_cnt} !== 86'd0) begin
            n_fail++; $display("FAIL reset_results: got %h expected 0", {o_sum, o_max_val, o_max_idx, o_nz_cnt}); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (o_busy !== 1'b0 || o_done !== 1'b0) begin
            n_fail++; $display("FAIL idle_after_reset: busy=%b done=%b expected 0 0", o_busy, o_done); end
    endtask

    task automatic test_basic();
        int lat;
        logic [6:0] exp_a [4];
        exp_a = '{7'd0, 7'd1, 7'd2, 7'd3};
        run_scan(7'd0, 8'd4, lat);
        n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL basic_latency: got %0d expected 5", lat); end
        n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_at_done: got %b expected 0", o_busy); end
        n_checks++; if (o_sum !== 39'h0ABCD1A45) begin n_fail++; $display("FAIL basic_sum: got %h expected 0abcd1a45", o_sum); end
        n_checks++; if (o_max_val !== 32'hABCD1234) begin n_fail++; $display("FAIL basic_max: got %h expected abcd1234", o_max_val); end
        n_checks++; if (o_max_idx !== 7'd1) begin n_fail++; $display("FAIL basic_idx: got %0d expected 1", o_max_idx); end
        n_checks++; if (o_nz_cnt !== 8'd4) begin n_fail++; $display("FAIL basic_nz: got %0d expected 4", o_nz_cnt); end
        repeat (3) @(posedge clk); #1;
        n_checks++; if (rd_cnt !== 4) begin n_fail++; $display("FAIL basic_rd_cycles: got %0d expected 4", rd_cnt); end
        n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL basic_done_pulses: got %0d expected 1", done_cnt); end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (addr_q.size() <= i || addr_q[i] !== exp_a[i]) begin
                n_fail++; $display("FAIL basic_addr[%0d]: got %0d expected %0d", i, (addr_q.size() > i) ? addr_q[i] : 7'h7f, exp_a[i]); end
        end
        n_checks++; if (o_sum !== 39'h0ABCD1A45) begin n_fail++; $display("FAIL basic_hold_sum: got %h expected 0abcd1a45", o_sum); end
    endtask

    task automatic test_wrap();
        int lat;
        logic [6:0] exp_a [4];
        exp_a = '{7'd126, 7'd127, 7'd0, 7'd1};
        run_scan(7'd126, 8'd4, lat);
        n_checks++; if (o_sum !== 39'h0ABCD1A34) begin n_fail++; $display("FAIL wrap_sum: got %h expected 0abcd1a34", o_sum); end
        n_checks++; if (o_max_val !== 32'hABCD1234 || o_max_idx !== 7'd1) begin
            n_fail++; $display("FAIL wrap_max: got %h@%0d expected abcd1234@1", o_max_val, o_max_idx); end
        n_checks++; if (o_nz_cnt !== 8'd2) begin n_fail++; $display("FAIL wrap_nz: got %0d expected 2", o_nz_cnt); end
        repeat (2) @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (addr_q.size() <= i || addr_q[i] !== exp_a[i]) begin
                n_fail++; $display("FAIL wrap_addr[%0d]: got %0d expected %0d", i, (addr_q.size() > i) ? addr_q[i] : 7'h7f, exp_a[i]); end
        end
    endtask

    task automatic test_base8();
        int lat;
        run_scan(7'd8, 8'd3, lat);
        n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL b8_latency: got %0d expected 4", lat); end
        n_checks++; if (o_max_val !== 32'h10000000 || o_max_idx !== 7'd9) begin
            n_fail++; $display("FAIL b8_max: got %h@%0d expected 10000000@9", o_max_val, o_max_idx); end
        n_checks++; if (o_sum !== 39'h0012000000 || o_nz_cnt !== 8'd3) begin
            n_fail++; $display("FAIL b8_sum_nz: got %h/%0d expected 12000000/3", o_sum, o_nz_cnt); end
    endtask

    task automatic test_first_zero();
        int lat;
        run_scan(7'd126, 8'd2, lat);
        n_checks++; if (o_max_val !== 32'd0 || o_max_idx !== 7'd126) begin
            n_fail++; $display("FAIL zero_first_max: got %h@%0d expected 0@126", o_max_val, o_max_idx); end
        n_checks++; if (o_sum !== 39'd0 || o_nz_cnt !== 8'd0) begin
            n_fail++; $display("FAIL zero_first_sum: got %h/%0d expected 0/0", o_sum, o_nz_cnt); end
    endtask

    task automatic test_len_zero();
        int lat;
        run_scan(7'd0, 8'd4, lat);
        run_scan(7'd5, 8'd0, lat);
        n_checks++; if (lat !== 0) begin n_fail++; $display("FAIL len0_latency: got %0d expected 0", lat); end
        n_checks++; if ({o_sum, o_max_val, o_max_idx, o_nz_cnt} !== 86'd0) begin
            n_fail++; $display("FAIL len0_results: got %h expected 0", {o_sum, o_max_val, o_max_idx, o_nz_cnt}); end
        repeat (3) @(posedge clk); #1;
        n_checks++; if (rd_cnt !== 0 || done_cnt !== 1) begin
            n_fail++; $display("FAIL len0_activity: rd=%0d done=%0d expected 0 1", rd_cnt, done_cnt); end
    endtask

    task automatic test_len_clamp();
        int lat;
        logic [38:0] exp_sum;
        exp_sum = '0;
        for (int i = 0; i < 128; i++) exp_sum = exp_sum + 39'(image[i]);
        run_scan(7'd0, 8'd200, lat);
        n_checks++; if (lat !== 129) begin n_fail++; $display("FAIL clamp_latency: got %0d expected 129", lat); end
        n_checks++; if (o_nz_cnt !== 8'd122) begin n_fail++; $display("FAIL clamp_nz: got %0d expected 122", o_nz_cnt); end
        n_checks++; if (o_sum !== exp_sum) begin n_fail++; $display("FAIL clamp_sum: got %h expected %h", o_sum, exp_sum); end
        n_checks++; if (o_max_val !== 32'hABCD1234 || o_max_idx !== 7'd1) begin
            n_fail++; $display("FAIL clamp_tie_max: got %h@%0d expected abcd1234@1", o_max_val, o_max_idx); end
        repeat (2) @(posedge clk); #1;
        n_checks++; if (rd_cnt !== 128) begin n_fail++; $display("FAIL clamp_rd_cycles: got %0d expected 128", rd_cnt); end
    endtask

    task automatic test_start_during_read();
        int lat;
        clear_mon();
        @(negedge clk);
        i_start = 1'b1; i_base_addr = 7'd0; i_len = 8'd4;
        @(posedge clk); #1;
        i_start = 1'b0;
        @(negedge clk);
        i_start = 1'b1; i_base_addr = 7'd8; i_len = 8'd3;
        @(posedge clk); #1;
        i_start = 1'b0;
        lat = 1;
        while (!o_done && lat < 400) begin
            @(posedge clk); #1;
            lat++;
        end
        n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL ign_latency: got %0d expected 5", lat); end
        n_checks++; if (o_sum !== 39'h0ABCD1A45 || o_max_idx !== 7'd1 || o_nz_cnt !== 8'd4) begin
            n_fail++; $display("FAIL ign_results: got %h/%0d/%0d expected 0abcd1a45/1/4", o_sum, o_max_idx, o_nz_cnt); end
        repeat (4) @(posedge clk); #1;
        n_checks++; if (rd_cnt !== 4 || done_cnt !== 1) begin
            n_fail++; $display("FAIL ign_activity: rd=%0d done=%0d expected 4 1", rd_cnt, done_cnt); end
    endtask

    task automatic test_reset_mid();
        int lat;
        clear_mon();
        @(negedge clk);
        i_start = 1'b1; i_base_addr = 7'd0; i_len = 8'd200;
        @(posedge clk); #1;
        i_start = 1'b0;
        repeat (6) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if ({o_mem_addr, o_mem_rd_en, o_busy, o_done} !== 10'd0) begin
            n_fail++; $display("FAIL midrst_ctrl: got %h expected 0", {o_mem_addr, o_mem_rd_en, o_busy, o_done}); end
        n_checks++; if ({o_sum, o_max_val, o_max_idx, o_nz_cnt} !== 86'd0) begin
            n_fail++; $display("FAIL midrst_results: got %h expected 0", {o_sum, o_max_val, o_max_idx, o_nz_cnt}); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk); #1;
        n_checks++; if (done_cnt !== 0) begin n_fail++; $display("FAIL midrst_no_done: got %0d expected 0", done_cnt); end
        run_scan(7'd8, 8'd3, lat);
        n_checks++; if (o_sum !== 39'h0012000000 || o_max_idx !== 7'd9 || o_nz_cnt !== 8'd3) begin
            n_fail++; $display("FAIL midrst_rescan: got %h/%0d/%0d expected 12000000/9/3", o_sum, o_max_idx, o_nz_cnt); end
    endtask

    task automatic test_back_to_back();
        int t;
        int seen;
        int first_t;
        int gap;
        clear_mon();
        @(negedge clk);
        i_start = 1'b1; i_base_addr = 7'd8; i_len = 8'd3;
        t = 0; seen = 0; first_t = 0; gap = 0;
        while (seen < 2 && t < 100) begin
            @(posedge clk); #1;
            if (o_done) begin
                seen++;
                if (seen == 1) first_t = t;
                else gap = t - first_t;
            end
            t++;
        end
        i_start = 1'b0;
        repeat (4) @(posedge clk); #1;
        n_checks++; if (gap !== 6) begin n_fail++; $display("FAIL b2b_gap: got %0d expected 6", gap); end
        n_checks++; if (rd_cnt !== 6 || done_cnt !== 2) begin
            n_fail++; $display("FAIL b2b_activity: rd=%0d done=%0d expected 6 2", rd_cnt, done_cnt); end
        n_checks++; if (o_sum !== 39'h0012000000 || o_max_val !== 32'h10000000) begin
            n_fail++; $display("FAIL b2b_results: got %h/%h expected 12000000/10000000", o_sum, o_max_val); end
    endtask

    initial begin
        n_checks = 0; n_fail = 0; rd_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 128; i++) image[i] = 32'h100 + i;
        image[0]  = 32'h00000800;
        image[1]  = 32'hABCD1234;
        image[2]  = 32'h00000010;
        image[3]  = 32'h00000001;
        image[8]  = 32'h01000000;
        image[9]  = 32'h10000000;
        image[10] = 32'h01000000;
        image[50] = 32'hABCD1234;
        for (int i = 40; i < 44; i++) image[i] = '0;
        image[126] = '0;
        image[127] = '0;
        test_reset();
        test_basic();
        test_wrap();
        test_base8();
        test_first_zero();
        test_len_zero();
        test_len_clamp();
        test_start_during_read();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_scan_unit.md
Name: mem_scan_unit

Overview:
- Engine that sits upstream of the 128x32 synchronous-read data memory and consumes its output.
- On start it sweeps a contiguous, wrapping address window and drives the memory's address and read-enable.
- It consumes each returned word and produces summary statistics: sum, unsigned maximum with its address, and nonzero-word count.
- Used by the lab top level to check memory contents without a CPU.

Parameters:
- ADDR_W, 7, memory address width (depth = 2**ADDR_W = 128).
- DATA_W, 32, memory word width.
- LEN_W, 8, width of the length field; must hold 2**ADDR_W.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a scan; sampled only in IDLE.
- base_addr  input  ADDR_W  first address of the window; sampled with start.
- len  input  LEN_W  number of words to read; sampled with start; 0 = no-op; values >128 are clamped to 128.
- mem_addr  output  ADDR_W  address to the data memory.
- mem_rd_en  output  1  read enable to the data memory.
- mem_data  input  DATA_W  memory read data; valid the cycle after a read enable is sampled.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse; results are valid from this cycle on.
- sum  output  DATA_W+ADDR_W (39)  unsigned sum of all words read; never overflows.
- max_val  output  DATA_W  largest unsigned word read.
- max_idx  output  ADDR_W  address of max_val.
- nz_cnt  output  LEN_W  count of words that are nonzero.

Behaviour:
- Reset (asynchronous): state = IDLE; all outputs 0, including mem_addr, mem_rd_en, busy, done and all results.
- Reset mid-scan aborts immediately; no done pulse is issued. The memory shares rst_n, so its output also clears.
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE:
  - start=1 latches base_addr and clamped len. It also clears sum, max_val, max_idx and nz_cnt.
  - If len=0, go to DONE; otherwise go to READ.
  - start is ignored in every other state.
- READ:
  - mem_rd_en=1 each cycle, with mem_addr = base + k (mod 128) for k = 0..len-1.
  - Addresses wrap from 127 to 0.
  - After the last issue, go to DRAIN.
- Capture pipeline:
  - A 1-bit valid register plus a delayed address register track each issue.
  - When valid=1, mem_data is accumulated into sum and nz_cnt.
  - max_val/max_idx are updated only if mem_data > max_val (strict). Ties therefore keep the earliest-read address.
  - The first word always loads max_val/max_idx, including a zero word.
- DRAIN: one cycle, mem_rd_en=0; the final word is captured. Then go to DONE.
- DONE: done=1 and busy=0 for one cycle, then return to IDLE.
- Results hold until the next accepted start, and remain stable while the memory's data_out holds its stale value.
- Timing: start sampled at edge T.
  - mem_rd_en is high for cycles T+1..T+len.
  - done is high in cycle T+len+2.
  - For len=0, done is high in cycle T+1 and all results are 0.
- busy is high in the READ and DRAIN states.
- start held high continuously triggers a new scan on the first IDLE cycle after DONE.

Decomposition:
- Shared package mem_pkg: ADDR_W, DATA_W, MEM_DEPTH, LEN_W, and the FSM state encoding.
- One natural sub-module: scan_accum. It holds the valid-qualified accumulator (sum, max/idx, nz_cnt) with clear and update inputs. The FSM and address generation stay in the top level.

Test Plan (run against the lab data memory image):
- base 0, len 4:
  - Expect mem_rd_en high for exactly 4 cycles, with addresses 0, 1, 2, 3.
  - Expect sum = 0x0ABCD1A45, max_val = 0xABCD1234, max_idx = 1, nz_cnt = 4.
  - Expect done exactly 6 cycles after the start edge.
- Wrap case, base 126, len 4:
  - Expect addresses 126, 127, 0, 1.
  - Expect sum = 0x0ABCD1A34, max_val = 0xABCD1234, max_idx = 1, nz_cnt = 2.
- base 8, len 3:
  - Expect max_val = 0x10000000, max_idx = 9, sum = 0x12000000, nz_cnt = 3.
- Edge lengths:
  - len = 0: expect done at T+1, all results 0, mem_rd_en never asserted.
  - len = 200: expect it clamped to 128 reads, with nz_cnt = 122 and done at T+130.
- Control robustness:
  - Pulse start during READ: it is ignored, and results match a single scan.
  - Pull rst_n low mid-READ: expect all outputs 0 immediately, no done pulse; a fresh scan afterwards gives correct results.
